// File: rtl/reg_bus_responder_pkg.sv
// Shared register-bus data type and the responder address map (decoded on addr[7:0]).
package reg_bus_responder_pkg;
  typedef logic [31:0] reg_data_t;

  localparam logic [7:0] RESP_CFG_BASE   = 8'h00;
  localparam logic [7:0] RESP_CNT_CTRL   = 8'h40;
  localparam logic [7:0] RESP_CNT_SEL    = 8'h44;
  localparam logic [7:0] RESP_CNT_LSB    = 8'h48;
  localparam logic [7:0] RESP_CNT_MSB    = 8'h4C;
  localparam logic [7:0] RESP_SOFT_RESET = 8'h50;
  localparam logic [7:0] RESP_SCRATCH    = 8'h54;
  localparam logic [7:0] RESP_ID         = 8'h58;

  function automatic logic [7:0] cfg_addr(int i);
    return RESP_CFG_BASE + 8'(4 * i);
  endfunction
endpackage

// File: rtl/reg_bus_responder_if.sv
// Tile register bus slice seen by one component: write strobe, read request, registered response.
interface reg_bus_responder_if;
  import reg_bus_responder_pkg::*;
  logic        wvalid;
  logic [15:0] waddr;
  logic [31:0] wdata;
  logic        arvalid;
  logic [15:0] araddr;
  logic        rvalid;
  reg_data_t   rdata;

  modport master (output wvalid, waddr, wdata, arvalid, araddr, input rvalid, rdata);
  modport slave  (input wvalid, waddr, wdata, arvalid, araddr, output rvalid, rdata);
endinterface

// File: rtl/reg_bus_responder_event_counter_bank.sv
// Event counter bank: enable/clear control, 64-bit saturating counters, LSB read with MSB shadow.
module event_counter_bank
  import reg_bus_responder_pkg::*;
#(
  parameter int          N_CNT       = 4,
  parameter logic [63:0] CNT_RST_VAL = 64'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [7:0]       waddr,
  input  logic [3:0]       wdata,
  input  logic             rd,
  input  logic [7:0]       raddr,
  input  logic [N_CNT-1:0] evt_inc,
  output reg_data_t        rd_data
);
  logic                   en_q;
  logic [3:0]             sel_q;
  logic [31:0]            shadow_q;
  logic [N_CNT-1:0][63:0] cnt_q;
  logic [63:0]            sel_cnt;
  logic                   wr_ctrl, clr;

  assign wr_ctrl = wr && (waddr == RESP_CNT_CTRL);
  assign clr     = wr_ctrl && wdata[1];

  // Out-of-range selects read as zero rather than aliasing a real counter.
  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < N_CNT; i++)
      if (sel_q == 4'(i)) sel_cnt = cnt_q[i];
  end

  always_comb begin
    case (raddr)
      RESP_CNT_CTRL: rd_data = {31'd0, en_q};
      RESP_CNT_SEL:  rd_data = {28'd0, sel_q};
      RESP_CNT_LSB:  rd_data = sel_cnt[31:0];
      RESP_CNT_MSB:  rd_data = shadow_q;
      default:       rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      sel_q    <= '0;
      shadow_q <= '0;
      cnt_q    <= {N_CNT{CNT_RST_VAL}};
    end else begin
      if (wr_ctrl) en_q <= wdata[0];
      if (wr && (waddr == RESP_CNT_SEL)) sel_q <= wdata;
      if (rd && (raddr == RESP_CNT_LSB)) shadow_q <= sel_cnt[63:32];
      for (int i = 0; i < N_CNT; i++) begin
        if (clr) cnt_q[i] <= '0;
        else if (en_q && evt_inc[i] && !(&cnt_q[i])) cnt_q[i] <= cnt_q[i] + 64'd1;
      end
    end
  end
endmodule

// File: rtl/reg_bus_responder.sv
// Component-side register bus endpoint: CFG/SCRATCH/ID registers, soft-reset pulser, optional
// event counters (enabled by REG_RESP_COUNTERS_EN). Reads answer one cycle after arvalid.
module reg_bus_responder
  import reg_bus_responder_pkg::*;
#(
  parameter int          COMP_ID     = 0,
  parameter int          N_CFG       = 8,
  parameter int          N_CNT       = 4,
  parameter int          SRST_CYCLES = 4,
  parameter logic [63:0] CNT_RST_VAL = 64'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_bus_responder_if.slave    reg_bus,
  output logic [N_CFG*32-1:0]   cfg_regs,
  output logic                  soft_rst,
  input  logic [N_CNT-1:0]      evt_inc
);
  localparam int SW = $clog2(SRST_CYCLES + 1);

  logic [N_CFG-1:0][31:0] cfg_q;
  reg_data_t              scratch_q, rd_val, cnt_rd;
  logic [SW-1:0]          srst_cnt;
  logic [7:0]             waddr, raddr;
  logic                   unused_hi;

  assign waddr     = reg_bus.waddr[7:0];
  assign raddr     = reg_bus.araddr[7:0];
  assign cfg_regs  = cfg_q;
  assign soft_rst  = (srst_cnt != '0);

`ifdef REG_RESP_COUNTERS_EN
  assign unused_hi = ^{reg_bus.waddr[15:8], reg_bus.araddr[15:8]};

  event_counter_bank #(.N_CNT(N_CNT), .CNT_RST_VAL(CNT_RST_VAL)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .wr      (reg_bus.wvalid),
    .waddr   (waddr),
    .wdata   (reg_bus.wdata[3:0]),
    .rd      (reg_bus.arvalid),
    .raddr   (raddr),
    .evt_inc (evt_inc),
    .rd_data (cnt_rd)
  );
`else
  localparam logic [63:0] unused_cnt_rst = CNT_RST_VAL;
  assign unused_hi = ^{reg_bus.waddr[15:8], reg_bus.araddr[15:8], evt_inc, unused_cnt_rst};
  assign cnt_rd    = '0;
`endif

  // Read mux sees only registered state, so a same-cycle write is not visible to the read.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < N_CFG; i++)
      if (raddr == cfg_addr(i)) rd_val = cfg_q[i];
    case (raddr)
      RESP_SCRATCH: rd_val = scratch_q;
      RESP_ID:      rd_val = reg_data_t'(COMP_ID);
      RESP_CNT_CTRL, RESP_CNT_SEL, RESP_CNT_LSB, RESP_CNT_MSB: rd_val = cnt_rd;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q          <= '0;
      scratch_q      <= '0;
      srst_cnt       <= '0;
      reg_bus.rvalid <= 1'b0;
      reg_bus.rdata  <= '0;
    end else begin
      reg_bus.rvalid <= reg_bus.arvalid;
      if (reg_bus.arvalid) reg_bus.rdata <= rd_val;
      if (reg_bus.wvalid) begin
        for (int i = 0; i < N_CFG; i++)
          if (waddr == cfg_addr(i)) cfg_q[i] <= reg_bus.wdata;
        if (waddr == RESP_SCRATCH) scratch_q <= reg_bus.wdata;
      end
      // A write while the pulse is active reloads and so extends it.
      if (reg_bus.wvalid && (waddr == RESP_SOFT_RESET)) srst_cnt <= SW'(SRST_CYCLES);
      else if (srst_cnt != '0)                          srst_cnt <= srst_cnt - SW'(1);
    end
  end
endmodule

// File: tb/tb_reg_bus_responder.sv
// Directed bench for reg_bus_responder: transaction-level model checked every cycle plus literal pins.
module tb_reg_bus_responder;
  import reg_bus_responder_pkg::*;
  localparam int N_CFG = 8, N_CNT = 4, SRST = 4, CID = 5;
`ifdef REG_RESP_COUNTERS_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N_CNT-1:0] inc = '0, inc2 = '0;
  logic [N_CFG*32-1:0] cfg_regs, cfg_regs2;
  logic soft_rst, soft_rst2;

  reg_bus_responder_if bus ();
  reg_bus_responder_if bus2 ();

  always #5 clk = ~clk;

  reg_bus_responder #(.COMP_ID(CID), .N_CFG(N_CFG), .N_CNT(N_CNT), .SRST_CYCLES(SRST)) dut (
    .clk(clk), .rst(rst), .reg_bus(bus), .cfg_regs(cfg_regs), .soft_rst(soft_rst), .evt_inc(inc));

  reg_bus_responder #(.COMP_ID(3), .N_CFG(N_CFG), .N_CNT(N_CNT), .SRST_CYCLES(SRST),
                      .CNT_RST_VAL(64'hFFFF_FFFF_FFFF_FFFE)) dut2 (
    .clk(clk), .rst(rst), .reg_bus(bus2), .cfg_regs(cfg_regs2), .soft_rst(soft_rst2), .evt_inc(inc2));

  // ---------------- model of the main instance ----------------
  int          cyc = 0;
  logic [31:0] m_cfg [N_CFG];
  logic [63:0] m_cnt [N_CNT];
  logic [31:0] m_scratch, m_shadow, m_rdata;
  logic [3:0]  m_sel;
  bit          m_en, m_rvalid;
  int          m_srst_last = -1;

  function automatic logic [63:0] m_selcnt();
    return (int'(m_sel) < N_CNT) ? m_cnt[int'(m_sel)] : 64'd0;
  endfunction

  function automatic logic [31:0] m_read(logic [7:0] a);
    if (a < 8'h40 && a[1:0] == 2'b00 && int'(a >> 2) < N_CFG) return m_cfg[int'(a >> 2)];
    if (a == 8'h54) return m_scratch;
    if (a == 8'h58) return 32'(CID);
    if (CNT_ON) begin
      logic [63:0] c;
      c = m_selcnt();
      if (a == 8'h40) return {31'd0, m_en};
      if (a == 8'h44) return {28'd0, m_sel};
      if (a == 8'h48) return c[31:0];
      if (a == 8'h4C) return m_shadow;
    end
    return 32'd0;
  endfunction

  initial forever begin
    logic [7:0] aw;
    bit clr;
    @(posedge clk);
    cyc++;
    if (rst) begin
      foreach (m_cfg[i]) m_cfg[i] = '0;
      foreach (m_cnt[i]) m_cnt[i] = '0;
      m_scratch = '0; m_shadow = '0; m_rdata = '0; m_sel = '0;
      m_en = 0; m_rvalid = 0; m_srst_last = -1;
    end else begin
      aw = bus.waddr[7:0];
      m_rvalid = bus.arvalid;
      if (bus.arvalid) begin
        logic [63:0] c;
        c = m_selcnt();
        m_rdata = m_read(bus.araddr[7:0]);
        if (CNT_ON && bus.araddr[7:0] == 8'h48) m_shadow = c[63:32];
      end
      clr = CNT_ON && bus.wvalid && aw == 8'h40 && bus.wdata[1];
      for (int i = 0; i < N_CNT; i++) begin
        if (clr) m_cnt[i] = '0;
        else if (m_en && inc[i] && m_cnt[i] != 64'hFFFF_FFFF_FFFF_FFFF) m_cnt[i] = m_cnt[i] + 1;
      end
      if (bus.wvalid) begin
        if (aw < 8'h40 && aw[1:0] == 2'b00 && int'(aw >> 2) < N_CFG) m_cfg[int'(aw >> 2)] = bus.wdata;
        if (aw == 8'h54) m_scratch = bus.wdata;
        if (aw == 8'h50) m_srst_last = cyc + SRST - 1;
        if (CNT_ON && aw == 8'h40) m_en = bus.wdata[0];
        if (CNT_ON && aw == 8'h44) m_sel = bus.wdata[3:0];
      end
    end
  end

  // ---------------- checking ----------------
  typedef struct { int cyc; int kind; logic [31:0] val; string nm; } lit_t;
  lit_t lq[$];
  int total = 0, bad = 0;

  task automatic expect_at(int c, int k, logic [31:0] v, string nm);
    lit_t e;
    e.cyc = c; e.kind = k; e.val = v; e.nm = nm;
    lq.push_back(e);
  endtask

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin : cmp
    lit_t e;
    logic [N_CFG*32-1:0] flat;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        for (int i = 0; i < N_CFG; i++) flat[i*32 +: 32] = m_cfg[i];
        chk("rvalid", 256'(bus.rvalid), 256'(m_rvalid));
        chk("rdata", 256'(bus.rdata), 256'(m_rdata));
        chk("soft_rst", 256'(soft_rst), 256'(cyc <= m_srst_last));
        chk("cfg_regs", 256'(cfg_regs), 256'(flat));
        chk("dut2_soft_rst", 256'(soft_rst2), 256'(0));
        chk("dut2_cfg_regs", 256'(cfg_regs2), 256'(0));
        while (lq.size() > 0 && lq[0].cyc <= cyc) begin
          e = lq.pop_front();
          case (e.kind)
            0: begin
              chk({e.nm, "_rvalid"}, 256'(bus.rvalid), 256'(1));
              chk(e.nm, 256'(bus.rdata), 256'(e.val));
            end
            1: chk(e.nm, 256'(soft_rst), 256'(e.val));
            2: chk(e.nm, 256'(cfg_regs[95:64]), 256'(e.val));
            3: chk(e.nm, 256'(bus.rvalid), 256'(0));
            default: begin
              chk({e.nm, "_rvalid"}, 256'(bus2.rvalid), 256'(1));
              chk(e.nm, 256'(bus2.rdata), 256'(e.val));
            end
          endcase
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
    bus.wvalid = 0; bus.arvalid = 0; bus2.wvalid = 0; bus2.arvalid = 0;
  endtask

  task automatic wr(logic [15:0] a, logic [31:0] d);
    bus.wvalid = 1; bus.waddr = a; bus.wdata = d;
    step();
  endtask

  task automatic rd(logic [15:0] a, bit lit, logic [31:0] v, string nm);
    bus.arvalid = 1; bus.araddr = a;
    if (lit) expect_at(cyc + 1, 0, v, nm);
    step();
  endtask

  task automatic wr2(logic [15:0] a, logic [31:0] d);
    bus2.wvalid = 1; bus2.waddr = a; bus2.wdata = d;
    step();
  endtask

  task automatic rd2(logic [15:0] a, logic [31:0] v, string nm);
    bus2.arvalid = 1; bus2.araddr = a;
    expect_at(cyc + 1, 4, v, nm);
    step();
  endtask

  initial begin
    int base;
    bus.wvalid = 0; bus.waddr = '0; bus.wdata = '0; bus.arvalid = 0; bus.araddr = '0;
    bus2.wvalid = 0; bus2.waddr = '0; bus2.wdata = '0; bus2.arvalid = 0; bus2.araddr = '0;
    repeat (2) step();
    expect_at(cyc + 1, 3, 0, "rst_rvalid");
    expect_at(cyc + 1, 1, 0, "rst_soft_rst");
    expect_at(cyc + 1, 2, 0, "rst_cfg2");
    step();
    rst = 0;
    step();

    // CFG write/readback, out-of-range CFG slot
    expect_at(cyc + 1, 2, 32'hDEADBEEF, "t1_cfg_regs2");
    wr(16'h0008, 32'hDEADBEEF);
    rd(16'h0008, 1, 32'hDEADBEEF, "t1_cfg2");
    wr(16'h0000, 32'h1111_0000);
    wr(16'h001C, 32'hA5A5_5A5A);
    rd(16'h001C, 1, 32'hA5A5_5A5A, "t1_cfg7");
    wr(16'h0020, 32'h1234_5678);
    rd(16'h0020, 1, 32'h0, "t1_cfg_oob");

    // ID, unmapped, RO write, upper address bits ignored
    rd(16'h0058, 1, 32'd5, "t2_id");
    rd(16'h007C, 1, 32'd0, "t2_unmapped");
    wr(16'h0058, 32'hFFFF_FFFF);
    rd(16'h0058, 1, 32'd5, "t2_id_ro");
    wr(16'h007C, 32'h0BAD_0BAD);
    rd(16'hAB08, 1, 32'hDEADBEEF, "t2_hi_addr");

    // counters
    wr(16'h0040, 32'h1);
    inc = 4'b0010;
    repeat (10) step();
    inc = 4'b0000;
    wr(16'h0044, 32'h1);
    rd(16'h0048, 1, CNT_ON ? 32'd10 : 32'd0, "t3_lsb");
    rd(16'h004C, 1, 32'd0, "t3_msb");
    inc = 4'b0011;
    wr(16'h0040, 32'h3);
    inc = 4'b0000;
    rd(16'h0048, 1, 32'd0, "t3_clr");
    rd(16'h0040, 1, CNT_ON ? 32'd1 : 32'd0, "t3_ctrl");

    // saturation on the preloaded instance
    wr2(16'h0040, 32'h1);
    inc2 = 4'b0001;
    repeat (3) step();
    inc2 = 4'b0000;
    rd2(16'h0048, CNT_ON ? 32'hFFFF_FFFF : 32'd0, "t4_lsb");
    rd2(16'h004C, CNT_ON ? 32'hFFFF_FFFF : 32'd0, "t4_msb");

    // soft reset pulse and extension
    base = cyc;
    for (int c = 1; c <= 6; c++) expect_at(base + c, 1, 1, "t5_srst_hi");
    expect_at(base + 7, 1, 0, "t5_srst_lo");
    wr(16'h0050, 32'h0);
    step();
    wr(16'h0050, 32'h0);
    repeat (6) step();

    // same-cycle write/read, reset aborts a pending read
    wr(16'h0054, 32'd3);
    bus.wvalid = 1; bus.waddr = 16'h0054; bus.wdata = 32'd7;
    rd(16'h0054, 1, 32'd3, "t6_old");
    rd(16'h0054, 1, 32'd7, "t6_new");
    rst = 1;
    expect_at(cyc + 1, 3, 0, "t6_rst_abort");
    rd(16'h0054, 0, 32'd0, "");
    rst = 0;
    rd(16'h0054, 1, 32'd0, "t6_scratch_rst");
    rd(16'h0008, 1, 32'd0, "t6_cfg_rst");
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
